core_seq_ctrl: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the Burn Rubber CPU core. It owns the program counter and instruction register and drives a single shared memory port for instruction fetch and load/store data. It also generates per-cycle control strobes for the core datapath (ALU, register file) for opcodes store=1, load=2, add=3, addi=4 and sub=5. It sits between the memory arbiter and the core datapath.

---
 rtl/core_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// Fetch/decode/execute sequencer for the Burn Rubber core: owns pc/instr and the shared memory port.
// Optional memory-ack watchdog enabled by defining CORE_SEQ_TIMEOUT_EN.
module core_seq_ctrl #(
  parameter logic [15:0] PC_RESET       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] data_addr,
  output logic [15:0] instr,
  output logic [15:0] ld_data,
  output logic        alu_op,
  output logic        alu_src_imm,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic        busy,
  output logic        illegal,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [3:0]  opcode;
  logic        at_boundary;

  assign opcode = instr[3:0];

  // Instruction boundary: the current instruction finishes on this edge.
  assign at_boundary = (state == EXEC) || (state == WB) ||
                       ((state == DECODE) && (opcode >= 4'd6)) ||
                       ((state == MEM) && mem_ack && mem_we);

`ifdef CORE_SEQ_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit = mem_req && !mem_ack && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  wire unused_cfg = (TIMEOUT_CYCLES == 0);
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      instr       <= '0;
      ld_data     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      alu_op      <= 1'b0;
      alu_src_imm <= 1'b0;
      rf_we       <= 1'b0;
      rf_wsel     <= 1'b0;
      busy        <= 1'b0;
      illegal     <= 1'b0;
`ifdef CORE_SEQ_TIMEOUT_EN
      fault       <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      rf_we       <= 1'b0;
      rf_wsel     <= 1'b0;
      alu_op      <= 1'b0;
      alu_src_imm <= 1'b0;
`ifdef CORE_SEQ_TIMEOUT_EN
      if (mem_req && !mem_ack) tmo_cnt <= tmo_cnt + 16'd1;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            illegal  <= 1'b0;
`ifdef CORE_SEQ_TIMEOUT_EN
            fault    <= 1'b0;
            tmo_cnt  <= '0;
`endif
          end
        end
        FETCH: begin
          if (mem_ack) begin
            instr   <= mem_rdata;
            pc      <= pc + 16'd1;
            mem_req <= 1'b0;
            state   <= DECODE;
          end
`ifdef CORE_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            mem_req <= 1'b0;
            fault   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
`endif
        end
        DECODE: begin
          case (opcode)
            4'd3, 4'd4, 4'd5: begin
              state       <= EXEC;
              rf_we       <= 1'b1;
              alu_op      <= (opcode == 4'd5);
              alu_src_imm <= (opcode == 4'd4);
            end
            4'd1, 4'd2: begin
              state    <= MEM;
              mem_req  <= 1'b1;
              mem_we   <= (opcode == 4'd1);
              mem_addr <= data_addr;
`ifdef CORE_SEQ_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
            end
            4'd0: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
            default: illegal <= 1'b1;
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              ld_data <= mem_rdata;
              state   <= WB;
              rf_we   <= 1'b1;
              rf_wsel <= 1'b1;
            end
          end
`ifdef CORE_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            fault   <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
`endif
        end
        EXEC, WB: begin
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Later assignments here override the per-state defaults above.
      if (at_boundary) begin
        if (stop) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state    <= FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
`ifdef CORE_SEQ_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl; a second instance with PC_RESET=16'hFFFF covers pc wrap.
// The watchdog scenario runs only when CORE_SEQ_TIMEOUT_EN is defined.
module tb_core_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start_w;
  logic        stop;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] data_addr;

  logic        mem_req, mem_we, alu_op, alu_src_imm, rf_we, rf_wsel, busy, illegal, fault;
  logic [15:0] mem_addr, instr, ld_data;

  logic        w_mem_req, w_mem_we, w_alu_op, w_alu_src_imm, w_rf_we, w_rf_wsel;
  logic        w_busy, w_illegal, w_fault;
  logic [15:0] w_mem_addr, w_instr, w_ld_data;

  int checks = 0;
  int errors = 0;

  core_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .data_addr(data_addr),
    .instr(instr), .ld_data(ld_data), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .busy(busy), .illegal(illegal), .fault(fault)
  );

  core_seq_ctrl #(.PC_RESET(16'hFFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w), .stop(stop),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .data_addr(data_addr),
    .instr(w_instr), .ld_data(w_ld_data), .alu_op(w_alu_op), .alu_src_imm(w_alu_src_imm),
    .rf_we(w_rf_we), .rf_wsel(w_rf_wsel), .busy(w_busy), .illegal(w_illegal), .fault(w_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic st, input logic sp, input logic ack,
                               input logic [15:0] rdata, input logic [15:0] daddr);
    start     = st;
    stop      = sp;
    mem_ack   = ack;
    mem_rdata = rdata;
    data_addr = daddr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_w = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_fault", fault, 0);
    rst_n = 1'b1;
    tick();

    // add 16'h0213 at pc 0
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("add_fetch_req", mem_req, 1);
    checkOutput("add_fetch_addr", mem_addr, 16'h0000);
    checkOutput("add_fetch_we", mem_we, 0);
    checkOutput("add_busy", busy, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0213, 16'h0000);
    tick();
    checkOutput("add_instr", instr, 16'h0213);
    checkOutput("add_decode_req", mem_req, 0);
    checkOutput("add_decode_rfwe", rf_we, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("add_exec_rfwe", rf_we, 1);
    checkOutput("add_exec_aluop", alu_op, 0);
    checkOutput("add_exec_imm", alu_src_imm, 0);
    checkOutput("add_exec_wsel", rf_wsel, 0);
    tick();
    checkOutput("add_next_req", mem_req, 1);
    checkOutput("add_next_addr", mem_addr, 16'h0001);
    checkOutput("add_next_rfwe", rf_we, 0);

    // load 16'h0022 at pc 1, two wait states
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0022, 16'h0000);
    tick();
    checkOutput("ld_instr", instr, 16'h0022);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0040);
    tick();
    checkOutput("ld_mem_req", mem_req, 1);
    checkOutput("ld_mem_addr", mem_addr, 16'h0040);
    checkOutput("ld_mem_we", mem_we, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234);
    tick();
    checkOutput("ld_wait_req", mem_req, 1);
    checkOutput("ld_wait_addr_hold", mem_addr, 16'h0040);
    tick();
    checkOutput("ld_wait2_req", mem_req, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h1234);
    tick();
    checkOutput("ld_data", ld_data, 16'hBEEF);
    checkOutput("ld_wb_rfwe", rf_we, 1);
    checkOutput("ld_wb_wsel", rf_wsel, 1);
    checkOutput("ld_wb_req", mem_req, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("ld_next_req", mem_req, 1);
    checkOutput("ld_next_addr", mem_addr, 16'h0002);
    checkOutput("ld_next_rfwe", rf_we, 0);

    // store 16'h0001 at pc 2
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000);
    tick();
    checkOutput("st_decode_rfwe", rf_we, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0080);
    tick();
    checkOutput("st_mem_req", mem_req, 1);
    checkOutput("st_mem_we", mem_we, 1);
    checkOutput("st_mem_addr", mem_addr, 16'h0080);
    checkOutput("st_mem_rfwe", rf_we, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    tick();
    checkOutput("st_next_addr", mem_addr, 16'h0003);
    checkOutput("st_next_we", mem_we, 0);
    checkOutput("st_next_rfwe", rf_we, 0);

    // illegal 16'h0009 at pc 3
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0009, 16'h0000);
    tick();
    checkOutput("ill_decode_flag", illegal, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("ill_flag", illegal, 1);
    checkOutput("ill_next_req", mem_req, 1);
    checkOutput("ill_next_addr", mem_addr, 16'h0004);

    // halt at pc 4
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("halt_busy", busy, 0);
    checkOutput("halt_req", mem_req, 0);
    checkOutput("halt_ill_sticky", illegal, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0213, 16'h0000);
    tick();
    checkOutput("idle_ack_busy", busy, 0);
    checkOutput("idle_ack_instr", instr, 16'h0000);

    // restart clears illegal; sub with stop raised mid-instruction
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("restart_addr", mem_addr, 16'h0005);
    checkOutput("restart_ill_clr", illegal, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0325, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("sub_rfwe", rf_we, 1);
    checkOutput("sub_aluop", alu_op, 1);
    checkOutput("sub_imm", alu_src_imm, 0);
    tick();
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_req", mem_req, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // pc wrap on the PC_RESET=16'hFFFF instance, addi 16'h5214
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    checkOutput("wrap_fetch_addr", w_mem_addr, 16'hFFFF);
    checkOutput("wrap_other_idle", busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5214, 16'h0000);
    tick();
    checkOutput("wrap_instr", w_instr, 16'h5214);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("addi_rfwe", w_rf_we, 1);
    checkOutput("addi_imm", w_alu_src_imm, 1);
    checkOutput("addi_aluop", w_alu_op, 0);
    tick();
    checkOutput("wrap_next_req", w_mem_req, 1);
    checkOutput("wrap_next_addr", w_mem_addr, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("wrap_halt_busy", w_busy, 0);

`ifdef CORE_SEQ_TIMEOUT_EN
    // fetch at pc 6 never acknowledged
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (7) tick();
    checkOutput("tmo_wait_req", mem_req, 1);
    checkOutput("tmo_wait_fault", fault, 0);
    tick();
    checkOutput("tmo_fault", fault, 1);
    checkOutput("tmo_req", mem_req, 0);
    checkOutput("tmo_busy", busy, 0);
`endif

    // load interrupted by reset while in MEM
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("rstmem_fetch_addr", mem_addr, 16'h0006);
    checkOutput("rstmem_fault_clr", fault, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0012, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0040);
    tick();
    checkOutput("rstmem_req", mem_req, 1);
    checkOutput("rstmem_addr", mem_addr, 16'h0040);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_req", mem_req, 0);
    checkOutput("async_addr", mem_addr, 16'h0000);
    checkOutput("async_instr", instr, 16'h0000);
    checkOutput("async_ld_data", ld_data, 16'h0000);
    checkOutput("async_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("pc_reset_addr", mem_addr, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
